// File: rtl/upp_rx_frame_checker.sv
// uPP receive deframer: checks sync, length and checksum, streams payload and counts frames/errors.
// Define UPP_RX_SEQ_CHECK_EN to also require consecutive sequence numbers in payload word 0.
module upp_rx_frame_checker #(
  parameter logic [15:0] SYNC_WORD     = 16'hF5F5,
  parameter int          PAYLOAD_WORDS = 16,
  parameter logic [8:0]  STROBE_DELAY  = 9'd200,
  parameter logic [8:0]  STROBE_LENGTH = 9'd200,
  parameter int          CNT_W         = 16
) (
  input  logic             iclk,
  input  logic             ireset,
  input  logic [15:0]      iDATA_UPP,
  input  logic             iENA,
  output logic [15:0]      oPAYLOAD_DATA,
  output logic             oPAYLOAD_VALID,
  output logic             oFRAME_OK,
  output logic             oFRAME_ERR,
  output logic [2:0]       oERR_CODE,
  output logic [CNT_W-1:0] oFRAME_CNT,
  output logic [CNT_W-1:0] oERR_CNT,
  output logic             oGPIO5
);

  localparam logic [2:0] ERR_NONE     = 3'd0;
  localparam logic [2:0] ERR_BAD_SYNC = 3'd1;
  localparam logic [2:0] ERR_SHORT    = 3'd2;
  localparam logic [2:0] ERR_BAD_SUM  = 3'd3;
  localparam logic [2:0] ERR_LONG     = 3'd4;
  localparam logic [2:0] ERR_SEQ      = 3'd5;

  typedef enum logic [2:0] {IDLE, PAYLOAD, CHK, FEND, DRAIN} state_t;
  typedef enum logic [1:0] {STB_IDLE, STB_DELAY, STB_HIGH} stbState_t;

  state_t     state;
  stbState_t  stbState;
  logic [15:0] sum;
  logic [7:0]  idx;
  logic        sumOk;
  logic [8:0]  stbTimer;
  logic [2:0]  errCode;
  logic        okNow;
`ifdef UPP_RX_SEQ_CHECK_EN
  logic [15:0] seqWord;
  logic [15:0] seqRef;
  logic        seqValid;
`endif

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Classify the word on the bus this cycle into an error or a frame acceptance
  always_comb begin
    errCode = ERR_NONE;
    okNow   = 1'b0;
    case (state)
      IDLE:         if (iENA && iDATA_UPP != SYNC_WORD) errCode = ERR_BAD_SYNC;
      PAYLOAD, CHK: if (!iENA) errCode = ERR_SHORT;
      FEND: begin
        if (iENA) errCode = ERR_LONG;
        else if (!sumOk) errCode = ERR_BAD_SUM;
`ifdef UPP_RX_SEQ_CHECK_EN
        else if (seqValid && seqWord != seqRef + 16'd1) errCode = ERR_SEQ;
`endif
        else okNow = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      state          <= IDLE;
      sum            <= '0;
      idx            <= '0;
      sumOk          <= 1'b0;
      oPAYLOAD_DATA  <= '0;
      oPAYLOAD_VALID <= 1'b0;
      oFRAME_OK      <= 1'b0;
      oFRAME_ERR     <= 1'b0;
      oERR_CODE      <= '0;
      oFRAME_CNT     <= '0;
      oERR_CNT       <= '0;
`ifdef UPP_RX_SEQ_CHECK_EN
      seqWord        <= '0;
      seqRef         <= '0;
      seqValid       <= 1'b0;
`endif
    end else begin
      oPAYLOAD_VALID <= 1'b0;
      oFRAME_OK      <= okNow;
      oFRAME_ERR     <= (errCode != ERR_NONE);
      if (errCode != ERR_NONE) begin
        oERR_CODE <= errCode;
        oERR_CNT  <= satInc(oERR_CNT);
      end
      if (okNow) oFRAME_CNT <= satInc(oFRAME_CNT);
      case (state)
        IDLE: if (iENA) begin
          if (iDATA_UPP == SYNC_WORD) begin
            sum   <= '0;
            idx   <= '0;
            state <= PAYLOAD;
          end else begin
            state <= DRAIN;
          end
        end
        PAYLOAD: if (iENA) begin
          oPAYLOAD_DATA  <= iDATA_UPP;
          oPAYLOAD_VALID <= 1'b1;
          sum            <= sum + iDATA_UPP;
          idx            <= idx + 8'd1;
`ifdef UPP_RX_SEQ_CHECK_EN
          if (idx == 8'd0) seqWord <= iDATA_UPP;
`endif
          if (idx == 8'(PAYLOAD_WORDS - 1)) state <= CHK;
        end else begin
          state <= IDLE;
        end
        CHK: if (iENA) begin
          sumOk <= (iDATA_UPP == sum);
          state <= FEND;
        end else begin
          state <= IDLE;
        end
        FEND: begin
          state <= iENA ? DRAIN : IDLE;
`ifdef UPP_RX_SEQ_CHECK_EN
          // Sequence failures still move the reference so one lost frame costs one error
          if (!iENA && sumOk) begin
            seqRef   <= seqWord;
            seqValid <= 1'b1;
          end
`endif
        end
        DRAIN: if (!iENA) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Start strobe: delay then high pulse, triggered by an accepted frame only when idle
  always_ff @(posedge iclk or posedge ireset) begin
    if (ireset) begin
      stbState <= STB_IDLE;
      stbTimer <= '0;
      oGPIO5   <= 1'b0;
    end else begin
      case (stbState)
        STB_IDLE: if (oFRAME_OK) begin
          if (STROBE_DELAY == 9'd0) begin
            stbState <= STB_HIGH;
            stbTimer <= STROBE_LENGTH - 9'd1;
            oGPIO5   <= 1'b1;
          end else begin
            stbState <= STB_DELAY;
            stbTimer <= STROBE_DELAY - 9'd1;
          end
        end
        STB_DELAY: if (stbTimer == 9'd0) begin
          stbState <= STB_HIGH;
          stbTimer <= STROBE_LENGTH - 9'd1;
          oGPIO5   <= 1'b1;
        end else begin
          stbTimer <= stbTimer - 9'd1;
        end
        STB_HIGH: if (stbTimer == 9'd0) begin
          stbState <= STB_IDLE;
          oGPIO5   <= 1'b0;
        end else begin
          stbTimer <= stbTimer - 9'd1;
        end
        default: stbState <= STB_IDLE;
      endcase
    end
  end

endmodule
